sram_port_initiator: RTL and testbench
======================================

SRAM_PORT_INITIATOR -- requirements
Module: sram_port_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter MASK_W, default 4, write-mask width; DATA_W is a multiple of MASK_W.
REQ-004 SHALL have parameter DEPTH, default 3, response FIFO entries; legal range is 2..8.
REQ-005 SHALL have port: clock  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: req_valid  in  1  request offered.
REQ-008 SHALL have port: req_ready  out  1  request accepted when req_valid is also high.
REQ-009 SHALL have port: req_write  in  1  1 = write, 0 = read.
REQ-010 SHALL have ports: req_addr in ADDR_W; req_wdata in DATA_W; req_wmask in MASK_W.
REQ-011 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out DATA_W; resp_is_wack out 1.
REQ-012 SHALL have ports: RW0_addr out ADDR_W; RW0_wdata out DATA_W; RW0_wmask out MASK_W; RW0_en out 1; RW0_wmode out 1; RW0_rdata in DATA_W.
REQ-013 SHALL drive the RW0_* ports active-high, with no inversion; the macro wrapper performs inversion.

Function
REQ-014 SHALL maintain inflight (0/1) = a read was issued last cycle, and count (0..DEPTH) = FIFO occupancy.
REQ-015 SHALL drive req_ready = (count + inflight < DEPTH), from registered state only, with no combinational path from resp_ready.
REQ-016 SHALL, on accept (req_valid & req_ready), drive RW0_en=1 in the same cycle, RW0_wmode=req_write, and RW0_addr/wdata/wmask from the request, combinationally.
REQ-017 SHALL, when there is no accept, hold RW0_en=0, RW0_wmode=0 and RW0_wmask=0; RW0_addr and RW0_wdata are don't-care.
REQ-018 SHALL treat read latency as exactly 1 cycle: RW0_rdata is sampled on the cycle after a read accept and pushed into the FIFO.
REQ-019 SHALL set RW0_wmask bit i to enable bytes/lanes [(i+1)*DATA_W/MASK_W-1 : i*DATA_W/MASK_W]; req_wmask passes through unmodified.
REQ-020 SHALL drive resp_valid = (count != 0), with resp_rdata and resp_is_wack taken from the FIFO head; pop when resp_valid & resp_ready.
REQ-021 SHALL support a simultaneous push and pop in the same cycle with count unchanged, including at count==DEPTH-1 and at count==1.
REQ-022 SHALL never overflow the FIFO; credit accounting guarantees this, and overflow is a verification assertion.
REQ-023 SHALL hold resp_rdata stable while resp_valid=1 and resp_ready=0.
REQ-024 SHALL wrap FIFO pointers modulo DEPTH for any DEPTH, including non-powers-of-two.
REQ-025 SHALL deliver responses in request order.
REQ-026 SHALL sustain 1 read per cycle with DEPTH>=3 and resp_ready held high.

Reset
REQ-027 SHALL, on reset_n low, immediately clear inflight, count and FIFO pointers.
REQ-028 SHALL force resp_valid=0, resp_rdata=0, resp_is_wack=0, RW0_en=0, RW0_wmode=0 and RW0_wmask=0 while reset_n is low.
REQ-029 SHALL drop any read in flight when reset is asserted mid-operation; no response for it appears after reset.
REQ-030 SHALL allow req_ready=1 on the first cycle after reset_n deasserts.

Configuration
REQ-031 SHALL, with SRAM_PORT_INITIATOR_WACK_EN defined, push a FIFO entry one cycle after each write accept, with resp_is_wack=1 and resp_rdata=0.
REQ-032 SHALL, in that configuration, make write accepts consume credit exactly like reads.
REQ-033 SHALL, with the macro undefined, make writes produce no response and consume no credit, and tie resp_is_wack to 0.

Structure
REQ-034 SHALL place the response-entry typedef (rdata, is_wack) and the default parameter constants in the shared package sram_port_pkg.
REQ-035 SHALL implement the FIFO as one sub-module, sram_port_resp_fifo, with parameters DEPTH and entry type, providing push, pop, count and head.

Verification
REQ-036 SHALL cover: reset, then read addr 0x05 with the model holding 0xDEAD_BEEF_0000_0005 -> RW0_en=1, RW0_wmode=0, addr=5 in cycle N; resp_valid=1 with that data in cycle N+2.
REQ-037 SHALL cover: write addr 0x1FF, data 0xA5.., mask 4'b0101 -> RW0_wmask=4'b0101, RW0_wmode=1; no response without the macro; with the macro, one wack response with rdata=0.
REQ-038 SHALL cover: resp_ready=0 and 5 read requests -> exactly 3 accepted, req_ready=0 afterwards, resp_rdata stable; then release -> 3 responses in order, remaining requests accepted.
REQ-039 SHALL cover: resp_ready=1 and 100 back-to-back reads at DEPTH=3 -> 100 accepts in 100 cycles, responses in order.
REQ-040 SHALL cover: reset_n pulsed low in the cycle after a read accept -> no response after reset, count=0, req_ready=1 on the next cycle.
REQ-041 SHALL cover: a random mix of reads and writes with random resp_ready at DEPTH=2 and DEPTH=5 -> scoreboard matches, and the no-overflow and no-pop-when-empty assertions hold.

Source files
------------

// File: rtl/sram_port_pkg.sv
// rtl/sram_port_pkg.sv - shared defaults and response entry type for the SRAM port initiator
package sram_port_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_MASK_W = 4;
  localparam int unsigned DEF_DEPTH  = 3;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  is_wack;
  } resp_entry_t;

endpackage

// File: rtl/sram_port_resp_fifo.sv
// rtl/sram_port_resp_fifo.sv - response FIFO with modulo-DEPTH pointers (any DEPTH, not only powers of two)
module sram_port_resp_fifo
  import sram_port_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter type         entry_t = resp_entry_t,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the head is only observed while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr_q];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count_q == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && (count_q == '0)));
`endif

endmodule

// File: rtl/sram_port_initiator.sv
// rtl/sram_port_initiator.sv - SRAM RW0 port initiator with credit-gated in-order response FIFO
// Define SRAM_PORT_INITIATOR_WACK_EN to return a write-ack entry for every accepted write.
module sram_port_initiator
  import sram_port_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_is_wack,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic              RW0_en,
  output logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Same shape as sram_port_pkg::resp_entry_t, sized to this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              is_wack;
  } entry_t;

  logic             inflight_q, inflight_d;
  logic             wack_q, wack_d;
  logic             wr_credit;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  entry_t           push_data;
  entry_t           head;

`ifdef SRAM_PORT_INITIATOR_WACK_EN
  assign wr_credit = 1'b1;
`else
  assign wr_credit = 1'b0;
`endif

  // Credit covers both queued entries and the one still in the SRAM pipeline.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q);
  assign req_ready = reset_n & (occupancy < (CNT_W+1)'(DEPTH));
  assign accept    = req_valid & req_ready;

  always_comb begin
    RW0_en            = accept;
    RW0_wmode         = accept & req_write;
    RW0_wmask         = accept ? req_wmask : '0;
    RW0_addr          = req_addr;
    RW0_wdata         = req_wdata;
    inflight_d        = accept & (~req_write | wr_credit);
    wack_d            = accept & req_write & wr_credit;
    push_data.rdata   = wack_q ? '0 : RW0_rdata;
    push_data.is_wack = wack_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      wack_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      wack_q     <= wack_d;
    end
  end

  sram_port_resp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign resp_valid   = (count != '0);
  assign resp_rdata   = resp_valid ? head.rdata : '0;
  assign resp_is_wack = resp_valid & head.is_wack;
  assign pop          = resp_valid & resp_ready;

endmodule

// File: tb/tb_sram_port_initiator.sv
// tb/tb_sram_port_initiator.sv - randomized self-checking bench for sram_port_initiator at DEPTH 3, 2 and 5
module tb_sram_port_initiator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        req_valid, req_write, resp_ready, mem_init;
  logic [8:0]  req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_wmask;

  logic        req_ready [3];
  logic        resp_valid [3];
  logic        resp_is_wack [3];
  logic        RW0_en [3];
  logic        RW0_wmode [3];
  logic [63:0] resp_rdata [3];
  logic [63:0] RW0_wdata [3];
  logic [63:0] RW0_rdata [3];
  logic [8:0]  RW0_addr [3];
  logic [3:0]  RW0_wmask [3];

  int vectors = 0;
  int errors  = 0;

  logic [63:0] ref_mem [3][512];
  logic [64:0] sb [3][256];
  int          wr_i [3];
  int          rd_i [3];

  function automatic logic [63:0] base(input int a);
    return 64'hDEAD_BEEF_0000_0000 | 64'(a);
  endfunction

  function automatic int dep(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 2 : 5);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned D = (g == 0) ? 3 : ((g == 1) ? 2 : 5);
    logic [63:0] mem [512];
    logic [63:0] rdata_q;

    sram_port_initiator #(.ADDR_W(9), .DATA_W(64), .MASK_W(4), .DEPTH(D)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready[g]),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_wmask    (req_wmask),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata[g]),
      .resp_is_wack (resp_is_wack[g]),
      .RW0_addr     (RW0_addr[g]),
      .RW0_wdata    (RW0_wdata[g]),
      .RW0_wmask    (RW0_wmask[g]),
      .RW0_en       (RW0_en[g]),
      .RW0_wmode    (RW0_wmode[g]),
      .RW0_rdata    (RW0_rdata[g])
    );

    // Behavioural single-port SRAM, one-cycle read latency, 16-bit mask lanes.
    always @(posedge clock) begin
      if (mem_init) begin
        for (int a = 0; a < 512; a++) mem[a] <= base(a);
      end else if (RW0_en[g]) begin
        if (RW0_wmode[g]) begin
          for (int i = 0; i < 4; i++)
            if (RW0_wmask[g][i]) mem[RW0_addr[g]][i*16 +: 16] <= RW0_wdata[g][i*16 +: 16];
        end else begin
          rdata_q <= mem[RW0_addr[g]];
        end
      end
    end
    assign RW0_rdata[g] = rdata_q;
  end

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic init_model();
    for (int g = 0; g < 3; g++) begin
      for (int a = 0; a < 512; a++) ref_mem[g][a] = base(a);
      wr_i[g] = 0;
      rd_i[g] = 0;
    end
  endtask

  task automatic apply_reset();
    idle();
    resp_ready = 1'b0;
    reset_n    = 1'b0;
    mem_init   = 1'b1;
    init_model();
    @(posedge clock); #1 mem_init = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_init = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h003; req_wdata = '1; req_wmask = 4'hF;
    init_model();
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      vectors++; if (resp_valid[g] !== 1'b0) begin errors++; $display("FAIL rst_resp_valid[%0d]: got %b want 0", g, resp_valid[g]); end
      vectors++; if (resp_rdata[g] !== 64'h0) begin errors++; $display("FAIL rst_resp_rdata[%0d]: got %h want 0", g, resp_rdata[g]); end
      vectors++; if (resp_is_wack[g] !== 1'b0) begin errors++; $display("FAIL rst_resp_is_wack[%0d]: got %b want 0", g, resp_is_wack[g]); end
      vectors++; if (RW0_en[g] !== 1'b0) begin errors++; $display("FAIL rst_rw0_en[%0d]: got %b want 0", g, RW0_en[g]); end
      vectors++; if (RW0_wmode[g] !== 1'b0) begin errors++; $display("FAIL rst_rw0_wmode[%0d]: got %b want 0", g, RW0_wmode[g]); end
      vectors++; if (RW0_wmask[g] !== 4'h0) begin errors++; $display("FAIL rst_rw0_wmask[%0d]: got %h want 0", g, RW0_wmask[g]); end
    end
    @(posedge clock); #1 mem_init = 1'b0; idle(); resp_ready = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_req_ready_after: got %b want 1", req_ready[0]); end
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_resp_valid_after: got %b want 0", resp_valid[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_read();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h005;
    @(negedge clock);
    vectors++; if (RW0_en[0] !== 1'b1) begin errors++; $display("FAIL rd_rw0_en: got %b want 1", RW0_en[0]); end
    vectors++; if (RW0_wmode[0] !== 1'b0) begin errors++; $display("FAIL rd_rw0_wmode: got %b want 0", RW0_wmode[0]); end
    vectors++; if (RW0_addr[0] !== 9'h005) begin errors++; $display("FAIL rd_rw0_addr: got %h want 005", RW0_addr[0]); end
    @(posedge clock); #1 idle();
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rd_early_resp: got %b want 0", resp_valid[0]); end
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b want 1", resp_valid[0]); end
    vectors++; if (resp_rdata[0] !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL rd_resp_rdata: got %h want deadbeef00000005", resp_rdata[0]); end
    vectors++; if (resp_is_wack[0] !== 1'b0) begin errors++; $display("FAIL rd_resp_is_wack: got %b want 0", resp_is_wack[0]); end
    @(posedge clock); #1 resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rd_after_pop: got %b want 0", resp_valid[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_write();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1FF;
    req_wdata = 64'hA5A5_A5A5_A5A5_A5A5; req_wmask = 4'b0101;
    @(negedge clock);
    vectors++; if (RW0_en[0] !== 1'b1) begin errors++; $display("FAIL wr_rw0_en: got %b want 1", RW0_en[0]); end
    vectors++; if (RW0_wmode[0] !== 1'b1) begin errors++; $display("FAIL wr_rw0_wmode: got %b want 1", RW0_wmode[0]); end
    vectors++; if (RW0_wmask[0] !== 4'b0101) begin errors++; $display("FAIL wr_rw0_wmask: got %b want 0101", RW0_wmask[0]); end
    vectors++; if (RW0_addr[0] !== 9'h1FF) begin errors++; $display("FAIL wr_rw0_addr: got %h want 1ff", RW0_addr[0]); end
    vectors++; if (RW0_wdata[0] !== 64'hA5A5_A5A5_A5A5_A5A5) begin errors++; $display("FAIL wr_rw0_wdata: got %h want a5a5a5a5a5a5a5a5", RW0_wdata[0]); end
    @(posedge clock); #1 idle();
    @(posedge clock); #1;
    @(negedge clock);
`ifdef SRAM_PORT_INITIATOR_WACK_EN
    vectors++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL wr_wack_valid: got %b want 1", resp_valid[0]); end
    vectors++; if (resp_is_wack[0] !== 1'b1) begin errors++; $display("FAIL wr_wack_flag: got %b want 1", resp_is_wack[0]); end
    vectors++; if (resp_rdata[0] !== 64'h0) begin errors++; $display("FAIL wr_wack_rdata: got %h want 0", resp_rdata[0]); end
`else
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got %b want 0", resp_valid[0]); end
`endif
    @(posedge clock); #1 resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h1FF;
    @(posedge clock); #1 idle();
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL wr_readback_valid: got %b want 1", resp_valid[0]); end
    vectors++; if (resp_rdata[0] !== 64'hDEAD_A5A5_0000_A5A5) begin errors++; $display("FAIL wr_readback_data: got %h want deada5a50000a5a5", resp_rdata[0]); end
    @(posedge clock); #1 resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_drained: got %b want 0", resp_valid[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (acc < 5); req_write = 1'b0; req_addr = 9'(10 + acc);
      @(negedge clock);
      if (c >= 2) begin
        vectors++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, resp_valid[0]); end
        vectors++; if (resp_rdata[0] !== base(10)) begin errors++; $display("FAIL bp_hold_rdata c%0d: got %h want %h", c, resp_rdata[0], base(10)); end
      end
      if (c == 7) begin
        vectors++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", req_ready[0]); end
      end
      if (req_valid && req_ready[0]) acc++;
      @(posedge clock); #1;
    end
    vectors++; if (acc !== 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", acc); end
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      req_valid = (acc < 5); req_write = 1'b0; req_addr = 9'(10 + acc);
      @(negedge clock);
      if (resp_valid[0]) begin
        vectors++; if (resp_rdata[0] !== base(10 + got)) begin errors++; $display("FAIL bp_order #%0d: got %h want %h", got, resp_rdata[0], base(10 + got)); end
        got++;
      end
      if (req_valid && req_ready[0]) acc++;
      @(posedge clock); #1;
    end
    idle(); resp_ready = 1'b0;
    vectors++; if (acc !== 5) begin errors++; $display("FAIL bp_total_accepts: got %0d want 5", acc); end
    vectors++; if (got !== 5) begin errors++; $display("FAIL bp_total_resps: got %0d want 5", got); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int sent_at_100 = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      req_valid = (sent < 100); req_write = 1'b0; req_addr = 9'(100 + sent);
      @(negedge clock);
      if (resp_valid[0]) begin
        vectors++; if (resp_rdata[0] !== base(100 + got)) begin errors++; $display("FAIL b2b_order #%0d: got %h want %h", got, resp_rdata[0], base(100 + got)); end
        got++;
      end
      if (req_valid && req_ready[0]) sent++;
      if (c == 99) sent_at_100 = sent;
      @(posedge clock); #1;
    end
    idle(); resp_ready = 1'b0;
    vectors++; if (sent_at_100 !== 100) begin errors++; $display("FAIL b2b_throughput: got %0d accepts in 100 cycles want 100", sent_at_100); end
    vectors++; if (got !== 100) begin errors++; $display("FAIL b2b_resps: got %0d want 100", got); end
  endtask

  task automatic test_reset_midop();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h007;
    @(negedge clock);
    vectors++; if (RW0_en[0] !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", RW0_en[0]); end
    @(posedge clock); #1 idle(); reset_n = 1'b0;
    @(negedge clock);
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got %b want 0", resp_valid[0]); end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", req_ready[0]); end
    vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_no_resp c0: got %b want 0", resp_valid[0]); end
    for (int c = 1; c < 4; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      vectors++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_no_resp c%0d: got %b want 0", c, resp_valid[0]); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int  occ;
    bit  exp_rdy, acc;
    apply_reset();
    for (int c = 0; c < 820; c++) begin
      if (c < 800) begin
        req_valid  = ($urandom_range(0, 9) < 7);
        req_write  = ($urandom_range(0, 9) < 4);
        req_addr   = 9'($urandom_range(0, 15));
        req_wdata  = {$urandom, $urandom};
        req_wmask  = 4'($urandom_range(0, 15));
        resp_ready = ($urandom_range(0, 9) < 6);
      end else begin
        idle();
        resp_ready = 1'b1;
      end
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
        occ     = wr_i[g] - rd_i[g];
        exp_rdy = (occ < dep(g));
        acc     = req_valid && exp_rdy;
        vectors++; if (req_ready[g] !== exp_rdy) begin errors++; $display("FAIL rnd_credit[%0d] c%0d: got %b want %b", g, c, req_ready[g], exp_rdy); end
        vectors++; if (RW0_en[g] !== acc) begin errors++; $display("FAIL rnd_rw0_en[%0d] c%0d: got %b want %b", g, c, RW0_en[g], acc); end
        if (resp_valid[g] && resp_ready) begin
          vectors++;
          if (occ == 0) begin
            errors++; $display("FAIL rnd_spurious[%0d] c%0d: got response %h want none", g, c, resp_rdata[g]);
          end else begin
            if ({resp_is_wack[g], resp_rdata[g]} !== sb[g][rd_i[g] % 256]) begin
              errors++; $display("FAIL rnd_resp[%0d] c%0d: got %h want %h", g, c, {resp_is_wack[g], resp_rdata[g]}, sb[g][rd_i[g] % 256]);
            end
            rd_i[g]++;
          end
        end
        if (acc) begin
          if (!req_write) begin
            sb[g][wr_i[g] % 256] = {1'b0, ref_mem[g][req_addr]};
            wr_i[g]++;
          end else begin
            for (int i = 0; i < 4; i++)
              if (req_wmask[i]) ref_mem[g][req_addr][i*16 +: 16] = req_wdata[i*16 +: 16];
`ifdef SRAM_PORT_INITIATOR_WACK_EN
            sb[g][wr_i[g] % 256] = {1'b1, 64'h0};
            wr_i[g]++;
`endif
          end
        end
      end
      @(posedge clock); #1;
    end
    resp_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      vectors++; if (wr_i[g] - rd_i[g] !== 0) begin errors++; $display("FAIL rnd_drain[%0d]: got %0d outstanding want 0", g, wr_i[g] - rd_i[g]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mem_init = 1'b0;
    resp_ready = 1'b0;
    idle();
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
